// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round constants, key generator states, round count.
package aes_pkg;

    localparam logic [3:0] NR = 4'd10;

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        RUN,
        HOLD
    } kg_state_t;

    localparam logic [7:0] RCON [10] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    // Rcon[r] for r in 1..10; other indices never reach the datapath.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        if (r >= 4'd1 && r <= NR) begin
            return RCON[r - 4'd1];
        end
        return 8'h00;
    endfunction

endpackage

// File: rtl/keysubword.sv
// SubWord(RotWord(word)) with the forward AES S-box; purely combinational.
module keysubword (
    input  logic [31:0] word,
    output logic [31:0] sub
);

    // Byte i of the S-box sits at bits [(255-i)*8 +: 8].
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] idx;
        idx = {~b, 3'b000};
        return SBOX[idx +: 8];
    endfunction

    logic [31:0] rot;

    assign rot = {word[23:0], word[31:24]};
    assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

endmodule

// File: rtl/round_key_gen.sv
// AES-128 round key sequencer: K0..K10 (encrypt) or PRE expansion then K10..K0 (decrypt), one key/clk.
// Latency: first key one cycle after accepted start (decrypt: eleven, or one on a cache hit); no backpressure, start honoured only in IDLE/HOLD.
// Optional K10 cache under `AES_KEYGEN_CACHE_EN lets a repeated decrypt key skip the PRE expansion.
module round_key_gen
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         dir,
    input  logic [127:0] key,
    output logic [127:0] roundKey,
    output logic         valid,
    output logic         done,
    output logic         busy
);

    kg_state_t    state;
    logic [3:0]   rnd;
    logic [127:0] kreg;
    logic         dir_q;

    logic [31:0]  w0, w1, w2, w3, inv_w3, sw_in, sw_out, t;
    logic [31:0]  f0, f1, f2, f3;
    logic         inverse, last, accept, cache_hit;
    logic [7:0]   rc;
    logic [127:0] nxt_key;

`ifdef AES_KEYGEN_CACHE_EN
    logic [127:0] key_q, cached_key, cached_k10;
    logic         cache_ok;
    assign cache_hit = dir && cache_ok && (key == cached_key);
`else
    assign cache_hit = 1'b0;
`endif

    assign {w0, w1, w2, w3} = kreg;
    assign inverse = dir_q && (state == RUN);
    assign inv_w3  = w3 ^ w2;

    // One S-box path serves both directions; the inverse step needs the recovered w3.
    assign sw_in = inverse ? inv_w3 : w3;
    assign rc    = inverse ? rcon(rnd) : rcon(rnd + 4'd1);

    keysubword u_sub (
        .word (sw_in),
        .sub  (sw_out)
    );

    assign t  = sw_out ^ {rc, 24'h0};
    assign f0 = w0 ^ t;
    assign f1 = w1 ^ f0;
    assign f2 = w2 ^ f1;
    assign f3 = w3 ^ f2;

    assign nxt_key = inverse ? {w0 ^ t, w1 ^ w0, w2 ^ w1, inv_w3} : {f0, f1, f2, f3};

    assign last   = dir_q ? (rnd == 4'd0) : (rnd == NR);
    assign accept = start && (state == IDLE || state == HOLD);

    assign roundKey = kreg;
    assign valid    = (state == RUN);
    assign done     = (state == HOLD) || ((state == RUN) && last);
    assign busy     = (state == PRE) || (state == RUN);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            rnd   <= 4'd0;
            kreg  <= 128'h0;
            dir_q <= 1'b0;
`ifdef AES_KEYGEN_CACHE_EN
            key_q      <= 128'h0;
            cached_key <= 128'h0;
            cached_k10 <= 128'h0;
            cache_ok   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        dir_q <= dir;
`ifdef AES_KEYGEN_CACHE_EN
                        key_q <= key;
`endif
                        if (cache_hit) begin
`ifdef AES_KEYGEN_CACHE_EN
                            kreg <= cached_k10;
`endif
                            rnd   <= NR;
                            state <= RUN;
                        end else begin
                            kreg  <= key;
                            rnd   <= 4'd0;
                            state <= dir ? PRE : RUN;
                        end
                    end
                end
                PRE: begin
                    kreg <= nxt_key;
                    rnd  <= rnd + 4'd1;
                    if (rnd == NR - 4'd1) begin
                        state <= RUN;
`ifdef AES_KEYGEN_CACHE_EN
                        cached_key <= key_q;
                        cached_k10 <= nxt_key;
                        cache_ok   <= 1'b1;
`endif
                    end
                end
                RUN: begin
                    if (last) begin
                        state <= HOLD;
`ifdef AES_KEYGEN_CACHE_EN
                        if (!dir_q) begin
                            cached_key <= key_q;
                            cached_k10 <= kreg;
                            cache_ok   <= 1'b1;
                        end
`endif
                    end else begin
                        kreg <= nxt_key;
                        rnd  <= dir_q ? rnd - 4'd1 : rnd + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/round_key_gen.md
# round_key_gen

Generates the AES-128 round-key sequence and feeds it to the cipher datapath, one 128-bit round key per clock. In encryption it streams K0..K10. In decryption it first expands forward to K10, then streams K10..K0 using the inverse key recurrence. It drives the cipher's `roundKey` and `done` inputs, so it sits directly upstream of the cipher stage.

## Interface
- No parameters. Key size is fixed at 128 bits, Nr = 10.
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin a schedule. Sampled only in IDLE or HOLD.
- dir  input  1  0 = encrypt order (K0 first), 1 = decrypt order (K10 first). Latched on accepted start.
- key  input  128  cipher key, latched on accepted start. [127:96] = w0 (FIPS-197 byte order).
- roundKey  output  128  current round key. Reset value 0.
- valid  output  1  roundKey is a schedule key this cycle. Reset value 0.
- done  output  1  last key of the schedule is on roundKey. Reset value 0.
- busy  output  1  state is PRE or RUN. Reset value 0.

## Operation
- **States:** IDLE, PRE, RUN, HOLD. A 4-bit round counter `rnd` accompanies the state.
- **Forward step.** With t = SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}:
  - w0' = w0 ^ t
  - w1' = w1 ^ w0'
  - w2' = w2 ^ w1'
  - w3' = w3 ^ w2'
- **Inverse step** (from K(r) to K(r-1)):
  - w3 = w3' ^ w2'
  - w2 = w2' ^ w1'
  - w1 = w1' ^ w0'
  - w0 = w0' ^ SubWord(RotWord(w3)) ^ {Rcon[r],24'h0}
  - SubWord always uses the forward S-box.
- **Rcon[1..10]:** 01,02,04,08,10,20,40,80,1b,36.
- **IDLE:** start → latch key/dir.
  - dir=0: go to RUN with rnd=0, key register = key.
  - dir=1: go to PRE with rnd=0.
- **PRE:** one forward step per cycle, rnd 1..10. After the 10th step go to RUN with rnd=10. valid=0, busy=1.
- **RUN:** roundKey = key register, valid=1, busy=1.
  - Each cycle the register advances one step: forward, or inverse if dir=1. rnd increments for dir=0, decrements for dir=1.
  - done=1 when rnd==10 (dir=0) or rnd==0 (dir=1). On that cycle go to HOLD.
- **HOLD:** roundKey holds the final key, done=1, valid=0, busy=0. The cipher freezes on done.
  - start → same as IDLE, and done drops next cycle.
- start in PRE/RUN is ignored. dir/key changes while busy are ignored.
- **reset asserted at any time:** immediately IDLE, all outputs and registers 0, any schedule abandoned.

## Timing
- An accepted start at edge E0 numbers the cycles after it as 1, 2, …
- **Encrypt:** K0 valid in cycle 1, K(n) in cycle n+1, K10 with done=1 in cycle 11. HOLD from cycle 12.
- **Decrypt:** PRE during cycles 1–10, K10 in cycle 11, K0 with done=1 in cycle 21.
- done is registered-state decoded, not combinational from start.
- Integration releases the cipher's reset one cycle before the first valid cycle, so the cipher's S0 coincides with the first key.
- start in HOLD on the same edge that done was first seen is accepted. The new K0/PRE begins in the next cycle.

## Configuration
- **`AES_KEYGEN_CACHE_EN` defined:** adds cached_key (128), cached_k10 (128) and cache_ok.
  - Filled with K10 at the end of any PRE or any encrypt RUN.
  - A decrypt start whose key equals cached_key with cache_ok=1 skips PRE: K10 appears in cycle 1, done in cycle 11.
  - Cleared by reset.
- **Not defined:** no cache storage. Every decrypt runs PRE (21-cycle schedule).

## Structure
- Shared package `aes_pkg`:
  - Rcon table (10×8-bit)
  - keygen state enum (IDLE, PRE, RUN, HOLD)
  - constant NR = 10
- One sub-module `keysubword`: 32-bit RotWord + 4 forward S-box lookups, combinational. It is shared by the forward and inverse step, with a mux selecting w3 or the recomputed w3.

## Test plan
- **Encrypt, FIPS-197 A.1 key** 2b7e151628aed2a6abf7158809cf4f3c, dir=0:
  - cycle 1 = that key
  - cycle 2 = a0fafe1788542cb123a339392a6c7605
  - cycle 11 = d014f9a8c9ee2589e13f0cc8b6630ca6 with done=1
  - valid high exactly cycles 1–11
- **Decrypt, same key, dir=1:**
  - valid=0, busy=1 for cycles 1–10
  - cycle 11 = d014f9a8…0ca6
  - cycle 12 = ac7766f319fadc2128d12941575c006e
  - cycle 21 = 2b7e1516…4f3c with done=1
- **Start while busy:** start with key 000102…0f at cycle 5 of an encrypt run → ignored, sequence matches the A.1 keys. Restart from HOLD with key 000102…0f → K10 = 13111d7fe3944a17f307a78b4d2b30c5.
- **Reset mid-operation:** reset low at cycle 6 of a decrypt run → roundKey/valid/done/busy all 0 asynchronously. After release, a new start yields a clean 11-cycle encrypt sequence.
- **With `AES_KEYGEN_CACHE_EN`:** encrypt A.1 key, then decrypt the same key → K10 in cycle 1, done in cycle 11. Decrypt a different key → full 21 cycles.
